// File: rtl/nor3_vector_sweeper_if.sv
// Signal bundle between the NOR-gate sweeper and the gate it exercises.
// The sweeper takes the slave side; whoever drives start and d_in takes the master side.
interface nor3_vector_sweeper_if #(
    parameter int ERR_W = 4
);
    logic             start;
    logic             d_in;
    logic             a;
    logic             b;
    logic             c;
    logic             busy;
    logic             done;
    logic             pass;
    logic [ERR_W-1:0] err_cnt;
    logic [2:0]       fail_vec;

    modport master (
        output start, d_in,
        input  a, b, c, busy, done, pass, err_cnt, fail_vec
    );

    modport slave (
        input  start, d_in,
        output a, b, c, busy, done, pass, err_cnt, fail_vec
    );
endinterface

// File: rtl/nor3_vector_sweeper.sv
// Drives all eight {a,b,c} vectors into a 3-input NOR (or OR) gate and checks each result.
// Optional macro STOP_ON_FAIL_EN ends the sweep on the first mismatching vector.
module nor3_vector_sweeper #(
    parameter int HOLD_CYCLES = 4,
    parameter int ERR_W       = 4,
    parameter int EXP_OR      = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    nor3_vector_sweeper_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0]       HOLD_LAST = 8'(HOLD_CYCLES - 1);
    localparam logic [ERR_W-1:0] ERR_MAX   = {ERR_W{1'b1}};
    localparam logic [ERR_W-1:0] ERR_ONE   = ERR_W'(1);
    localparam bit               CHECK_OR  = (EXP_OR != 0);

    state_t           state_q, state_d;
    logic [2:0]       v_q, v_d;
    logic [7:0]       h_q, h_d;
    logic [2:0]       abc_q, abc_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [ERR_W-1:0] errCnt_q, errCnt_d;
    logic [2:0]       failVec_q, failVec_d;
    logic             mismatchSeen_q, mismatchSeen_d;

    logic             expBit;
    logic             mismatch;
    logic             sampleEdge;
    logic             seenAfter;
    logic             stopNow;

    // The gate output is only trusted on the last hold cycle, which leaves settling time.
    always_comb begin
        expBit     = CHECK_OR ? (|v_q) : ~(|v_q);
        mismatch   = (bus.d_in != expBit);
        sampleEdge = (state_q == RUN) && (h_q == HOLD_LAST);
        seenAfter  = mismatchSeen_q | mismatch;
`ifdef STOP_ON_FAIL_EN
        stopNow    = (v_q == 3'd7) || mismatch;
`else
        stopNow    = (v_q == 3'd7);
`endif
    end

    always_comb begin
        state_d        = state_q;
        v_d            = v_q;
        h_d            = h_q;
        abc_d          = abc_q;
        busy_d         = busy_q;
        done_d         = done_q;
        pass_d         = pass_q;
        errCnt_d       = errCnt_q;
        failVec_d      = failVec_q;
        mismatchSeen_d = mismatchSeen_q;

        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d        = RUN;
                    busy_d         = 1'b1;
                    done_d         = 1'b0;
                    pass_d         = 1'b0;
                    errCnt_d       = '0;
                    failVec_d      = 3'b000;
                    v_d            = 3'd0;
                    h_d            = 8'd0;
                    abc_d          = 3'b000;
                    mismatchSeen_d = 1'b0;
                end
            end

            RUN: begin
                if (sampleEdge) begin
                    if (mismatch) begin
                        if (errCnt_q != ERR_MAX) begin
                            errCnt_d = errCnt_q + ERR_ONE;
                        end
                        if (!mismatchSeen_q) begin
                            failVec_d = v_q;
                        end
                    end
                    mismatchSeen_d = seenAfter;

                    // pass comes from the sticky flag so a saturated counter cannot hide failures.
                    if (stopNow) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = ~seenAfter;
                        abc_d   = 3'b000;
                        v_d     = 3'd0;
                        h_d     = 8'd0;
                    end else begin
                        v_d   = v_q + 3'd1;
                        abc_d = v_q + 3'd1;
                        h_d   = 8'd0;
                    end
                end else begin
                    h_d = h_q + 8'd1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            v_q            <= 3'd0;
            h_q            <= 8'd0;
            abc_q          <= 3'b000;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            pass_q         <= 1'b0;
            errCnt_q       <= '0;
            failVec_q      <= 3'b000;
            mismatchSeen_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            v_q            <= v_d;
            h_q            <= h_d;
            abc_q          <= abc_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            pass_q         <= pass_d;
            errCnt_q       <= errCnt_d;
            failVec_q      <= failVec_d;
            mismatchSeen_q <= mismatchSeen_d;
        end
    end

    assign bus.a        = abc_q[2];
    assign bus.b        = abc_q[1];
    assign bus.c        = abc_q[0];
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.pass     = pass_q;
    assign bus.err_cnt  = errCnt_q;
    assign bus.fail_vec = failVec_q;
endmodule

// File: tb/tb_nor3_vector_sweeper.sv
// Scoreboard bench: each sweep uses a random 8-entry gate response table; a behavioural
// model predicts the result, and a monitor checks vector stepping and final status.
module tb_nor3_vector_sweeper;
    localparam int HOLD    = 4;
    localparam int ERR_W   = 3;
    localparam int EXP_OR  = 0;
    localparam int ERR_MAX = (1 << ERR_W) - 1;
    localparam int NSWEEP  = 24;

    typedef struct {
        int errCnt;
        int failVec;
        int pass;
        int busyCycles;
    } expT;

    logic       clk;
    logic       rst;
    logic [7:0] respTable;
    expT        sbQ[$];
    int         tests;
    int         fails;

    nor3_vector_sweeper_if #(.ERR_W(ERR_W)) bus ();

    nor3_vector_sweeper #(
        .HOLD_CYCLES (HOLD),
        .ERR_W       (ERR_W),
        .EXP_OR      (EXP_OR)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Behavioural gate: its output for each input vector comes from the current table.
    assign bus.d_in = respTable[{bus.a, bus.b, bus.c}];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit wantBit(int i);
        if (EXP_OR != 0) return (i != 0);
        return (i == 0);
    endfunction

    function automatic expT refModel(logic [7:0] tbl);
        expT e;
        int  cnt;
        int  first;
        cnt   = 0;
        first = -1;
        for (int i = 0; i < 8; i++) begin
            if (tbl[i] != wantBit(i)) begin
                cnt++;
                if (first < 0) first = i;
            end
        end
`ifdef STOP_ON_FAIL_EN
        if (cnt > 0) begin
            e.errCnt     = 1;
            e.failVec    = first;
            e.pass       = 0;
            e.busyCycles = (first + 1) * HOLD;
            return e;
        end
`endif
        e.errCnt     = (cnt > ERR_MAX) ? ERR_MAX : cnt;
        e.failVec    = (first < 0) ? 0 : first;
        e.pass       = (cnt == 0) ? 1 : 0;
        e.busyCycles = 8 * HOLD;
        return e;
    endfunction

    task automatic checkOutput(string name, int actual, int expected);
        tests++;
        if (actual != expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkAllZero(string name);
        checkOutput({name, ".abc"},     {bus.a, bus.b, bus.c}, 0);
        checkOutput({name, ".busy"},    bus.busy, 0);
        checkOutput({name, ".done"},    bus.done, 0);
        checkOutput({name, ".pass"},    bus.pass, 0);
        checkOutput({name, ".errCnt"},  bus.err_cnt, 0);
        checkOutput({name, ".failVec"}, bus.fail_vec, 0);
    endtask

    // One sweep: pick a gate behaviour, predict, start, optionally disturb, await done.
    task automatic applyStimulus(int s);
        int         mode;
        int         action;
        int         k;
        int         cyc;
        logic [7:0] tbl;
        expT        e;

        mode = (s < 5) ? s : int'($urandom_range(0, 4));
        for (int i = 0; i < 8; i++) begin
            case (mode)
                0:       tbl[i] = wantBit(i);
                1:       tbl[i] = 1'b0;
                2:       tbl[i] = 1'b1;
                3:       tbl[i] = ~wantBit(i);
                default: tbl[i] = 1'($urandom_range(0, 1));
            endcase
        end
        e = refModel(tbl);

        if (s < 5)       action = 0;
        else if (s == 5) action = 1;
        else if (s == 6) action = 2;
        else             action = int'($urandom_range(0, 2));
        if (action != 0 && e.busyCycles < 3) action = 0;
        k = (action != 0) ? int'($urandom_range(1, e.busyCycles - 2)) : 0;

        @(negedge clk);
        respTable = tbl;
        bus.start = 1'b1;
        if (action != 2) sbQ.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;

        if (action == 2) begin
            repeat (k - 1) @(negedge clk);
            rst = 1'b1;
            @(posedge clk);
            #1;
            checkAllZero("midSweepReset");
            @(negedge clk);
            rst = 1'b0;
            return;
        end

        if (action == 1) begin
            repeat (k - 1) @(negedge clk);
            bus.start = 1'b1;
            @(negedge clk);
            bus.start = 1'b0;
        end

        cyc = 0;
        while (!bus.done && cyc < 8 * HOLD + 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        if (!bus.done) begin
            checkOutput("doneTimeout", 0, 1);
        end
    endtask

    // Monitor: checks the vector each busy cycle and pops the scoreboard when done rises.
    initial begin
        int  busyCnt;
        bit  prevDone;
        expT e;
        busyCnt  = 0;
        prevDone = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                busyCnt  = 0;
                prevDone = bus.done;
            end else begin
                if (bus.busy) begin
                    checkOutput("abcStep", {bus.a, bus.b, bus.c}, (busyCnt / HOLD) % 8);
                    busyCnt++;
                end
                if (bus.done && !prevDone) begin
                    if (sbQ.size() == 0) begin
                        checkOutput("unexpectedDone", 1, 0);
                    end else begin
                        e = sbQ.pop_front();
                        checkOutput("errCnt",     bus.err_cnt, e.errCnt);
                        checkOutput("failVec",    bus.fail_vec, e.failVec);
                        checkOutput("pass",       bus.pass, e.pass);
                        checkOutput("busyCycles", busyCnt, e.busyCycles);
                        checkOutput("abcAtDone",  {bus.a, bus.b, bus.c}, 0);
                        checkOutput("busyAtDone", bus.busy, 0);
                    end
                    busyCnt = 0;
                end
                prevDone = bus.done;
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        tests     = 0;
        fails     = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        respTable = 8'h00;
        repeat (3) @(negedge clk);
        checkAllZero("resetState");
        rst = 1'b0;

        for (int s = 0; s < NSWEEP; s++) begin
            applyStimulus(s);
            if (s == 10) begin
                @(negedge clk);
                rst       = 1'b1;
                bus.start = 1'b1;
                @(posedge clk);
                #1;
                checkAllZero("rstBeatsStart");
                @(negedge clk);
                rst       = 1'b0;
                bus.start = 1'b0;
            end
        end

        repeat (5) @(negedge clk);
        checkOutput("scoreboardEmpty", sbQ.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
